// File: rtl/gpu_pkg.sv
// Shared GPU pipeline definitions: arbiter state encoding, default bus widths
// and the framebuffer base address that all clients use.
package gpu_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned GPU_NUM_REQ     = 3;
  localparam int unsigned GPU_ADDR_W      = 30;
  localparam int unsigned GPU_DATA_W      = 32;
  localparam int unsigned GPU_BE_W        = 4;
  localparam int unsigned GPU_ARB_TIMEOUT = 255;

  localparam logic [GPU_ADDR_W-1:0] GPU_FB_BASE = 30'h32000000;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: one-hot grant for the first valid requester
// found searching upward from last_grant_i + 1, wrapping modulo NUM_REQ.
module rr_priority_pick
  import gpu_pkg::*;
#(
  parameter  int unsigned NUM_REQ = GPU_NUM_REQ,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  logic [IDX_W-1:0] cand_s;
  logic             found_s;
  logic             hit_s;

  // Walk candidates in rotating order; the first valid one wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found_s     = 1'b0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_s          = IDX_W'((32'(last_grant_i) + k) % NUM_REQ);
      hit_s           = valid_i[cand_s] & ~found_s;
      grant_o[cand_s] = grant_o[cand_s] | hit_s;
      grant_idx_o     = hit_s ? cand_s : grant_idx_o;
      found_s         = found_s | hit_s;
    end
  end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter sharing the GPU master port between pipeline clients.
// Optional acknowledge watchdog is enabled by defining GPU_ARB_ACK_TIMEOUT_EN.
module gpu_mem_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_REQ        = GPU_NUM_REQ,
  parameter int unsigned ADDR_W         = GPU_ADDR_W,
  parameter int unsigned DATA_W         = GPU_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = GPU_ARB_TIMEOUT
) (
  input  logic                    pll_clock,
  input  logic                    sys_reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*4-1:0]    req_byte_enable,
  input  logic [NUM_REQ*DATA_W-1:0] req_write_data,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [DATA_W-1:0]       rsp_read_data,
  output logic                    rsp_error,
  output logic [ADDR_W-1:0]       gpu_main_external_interface_address,
  output logic [3:0]              gpu_main_external_interface_byte_enable,
  output logic                    gpu_main_external_interface_read,
  output logic                    gpu_main_external_interface_write,
  output logic [DATA_W-1:0]       gpu_main_external_interface_write_data,
  input  logic                    gpu_main_external_interface_acknowledge,
  input  logic [DATA_W-1:0]       gpu_main_external_interface_read_data
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [IDX_W-1:0]   owner_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [3:0]         be_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               bus_rd_q;
  logic               bus_wr_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_error_q;

  logic [NUM_REQ-1:0] pick_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               grant_en_s;
  logic               sel_wr_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [3:0]         sel_be_s;
  logic [DATA_W-1:0]  sel_wdata_s;

`ifdef GPU_ARB_ACK_TIMEOUT_EN
  localparam int unsigned TMR_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMR_W-1:0] timer_q;
`endif

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_s),
    .grant_idx_o  (pick_idx_s)
  );

  // Grants are offered only from IDLE and never while reset is held.
  assign grant_en_s = (state_q == ARB_IDLE) && !sys_reset;
  assign req_ready  = grant_en_s ? pick_s : '0;

  // Select the granted requester's command fields (pick_s is one-hot or zero).
  always_comb begin
    sel_wr_s    = 1'b0;
    sel_addr_s  = '0;
    sel_be_s    = '0;
    sel_wdata_s = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      sel_wr_s    = sel_wr_s | (req_write[n] & pick_s[n]);
      sel_addr_s  = sel_addr_s | (req_address[n*ADDR_W +: ADDR_W] & {ADDR_W{pick_s[n]}});
      sel_be_s    = sel_be_s | (req_byte_enable[n*4 +: 4] & {4{pick_s[n]}});
      sel_wdata_s = sel_wdata_s | (req_write_data[n*DATA_W +: DATA_W] & {DATA_W{pick_s[n]}});
    end
  end

  // Arbiter FSM with latched bus command and response registers.
  always_ff @(posedge pll_clock) begin
    if (sys_reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      bus_rd_q     <= 1'b0;
      bus_wr_q     <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
`ifdef GPU_ARB_ACK_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      rsp_valid_q <= '0;
      rsp_error_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (|pick_s) begin
            wr_q         <= sel_wr_s;
            addr_q       <= sel_addr_s;
            be_q         <= sel_be_s;
            wdata_q      <= sel_wdata_s;
            owner_q      <= pick_idx_s;
            last_grant_q <= pick_idx_s;
            bus_rd_q     <= !sel_wr_s;
            bus_wr_q     <= sel_wr_s;
            state_q      <= ARB_BUSY;
`ifdef GPU_ARB_ACK_TIMEOUT_EN
            timer_q      <= TMR_W'(1);
`endif
          end
        end
        ARB_BUSY: begin
          if (gpu_main_external_interface_acknowledge) begin
            bus_rd_q             <= 1'b0;
            bus_wr_q             <= 1'b0;
            rsp_valid_q[owner_q] <= 1'b1;
            rsp_data_q           <= wr_q ? {DATA_W{1'b0}} : gpu_main_external_interface_read_data;
            state_q              <= ARB_IDLE;
          end
`ifdef GPU_ARB_ACK_TIMEOUT_EN
          // An ack on the limit cycle is handled above and takes priority.
          else if (timer_q >= TMR_W'(TIMEOUT_CYCLES)) begin
            bus_rd_q             <= 1'b0;
            bus_wr_q             <= 1'b0;
            rsp_valid_q[owner_q] <= 1'b1;
            rsp_data_q           <= '0;
            rsp_error_q          <= 1'b1;
            state_q              <= ARB_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
`endif
        end
        default: begin
          bus_rd_q <= 1'b0;
          bus_wr_q <= 1'b0;
          state_q  <= ARB_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid                               = rsp_valid_q;
  assign rsp_read_data                           = rsp_data_q;
  assign rsp_error                               = rsp_error_q;
  assign gpu_main_external_interface_address     = addr_q;
  assign gpu_main_external_interface_byte_enable = be_q;
  assign gpu_main_external_interface_read        = bus_rd_q;
  assign gpu_main_external_interface_write       = bus_wr_q;
  assign gpu_main_external_interface_write_data  = wdata_q;

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Scoreboard bench for gpu_mem_arbiter: a transaction-level model predicts grants,
// bus commands and responses; a negedge monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_gpu_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef GPU_ARB_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic sys_reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_address = '0;
  logic [N*4-1:0]  req_byte_enable = '0;
  logic [N*DW-1:0] req_write_data = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_read_data;
  logic            rsp_error;
  logic [AW-1:0]   bus_addr;
  logic [3:0]      bus_be;
  logic            bus_rd;
  logic            bus_wr;
  logic [DW-1:0]   bus_wdata;
  logic            bus_ack = 1'b0;
  logic [DW-1:0]   bus_rdata = '0;

  always #5 clk = ~clk;

  gpu_mem_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pll_clock                               (clk),
    .sys_reset                               (sys_reset),
    .req_valid                               (req_valid),
    .req_ready                               (req_ready),
    .req_write                               (req_write),
    .req_address                             (req_address),
    .req_byte_enable                         (req_byte_enable),
    .req_write_data                          (req_write_data),
    .rsp_valid                               (rsp_valid),
    .rsp_read_data                           (rsp_read_data),
    .rsp_error                               (rsp_error),
    .gpu_main_external_interface_address     (bus_addr),
    .gpu_main_external_interface_byte_enable (bus_be),
    .gpu_main_external_interface_read        (bus_rd),
    .gpu_main_external_interface_write       (bus_wr),
    .gpu_main_external_interface_write_data  (bus_wdata),
    .gpu_main_external_interface_acknowledge (bus_ack),
    .gpu_main_external_interface_read_data   (bus_rdata)
  );

  typedef struct { logic wr; logic [AW-1:0] addr; logic [3:0] be; logic [DW-1:0] data; } cmd_t;
  typedef struct { logic [DW-1:0] data; logic err; } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  cmd_t slot[N];

  // Reference model state (transaction level).
  bit m_started = 1'b0, m_busy = 1'b0, m_dir_wr = 1'b0, m_rsp_due = 1'b0, m_after_rst = 1'b0;
  int m_last = N - 1, m_owner = 0, m_rsp_owner = 0, m_wait = 0, m_busy_cnt = 0;
  int force_wait = -1;
  bit force_rd_en = 1'b0;
  logic [DW-1:0] force_rd = '0;
  logic [N-1:0] clr_mask = '0;

  int n_checks = 0, n_pass = 0;

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int p);
    logic [N-1:0] v;
    v = '0;
    if (p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic load(input int n, input logic wr, input logic [AW-1:0] a,
                      input logic [3:0] be, input logic [DW-1:0] d);
    if (!req_valid[n]) begin
      slot[n].wr = wr; slot[n].addr = a; slot[n].be = be; slot[n].data = d;
      req_write[n] = wr;
      req_address[n*AW +: AW] = a;
      req_byte_enable[n*4 +: 4] = be;
      req_write_data[n*DW +: DW] = d;
      req_valid[n] = 1'b1;
    end
  endtask

  task automatic load_rand(input int n);
    load(n, 1'($urandom_range(0, 1)), AW'($urandom), 4'($urandom), DW'($urandom));
  endtask

  // Advance the model over one clock edge using the inputs of the ending cycle.
  task automatic model_edge();
    int p;
    rsp_t r;
    m_started = 1'b1;
    m_rsp_due = 1'b0;
    if (sys_reset) begin
      m_busy = 1'b0; m_last = N - 1; m_after_rst = 1'b1;
    end else if (m_busy) begin
      m_busy_cnt++;
      if (bus_ack) begin
        r.data = m_dir_wr ? 32'h0 : bus_rdata; r.err = 1'b0;
        rsp_q.push_back(r);
        m_busy = 1'b0; m_rsp_due = 1'b1; m_rsp_owner = m_owner;
      end else if (TO_EN && m_busy_cnt == TO) begin
        r.data = 32'h0; r.err = 1'b1;
        rsp_q.push_back(r);
        m_busy = 1'b0; m_rsp_due = 1'b1; m_rsp_owner = m_owner;
      end else if (m_wait > 0) begin
        m_wait--;
      end
    end else begin
      p = pick(req_valid, m_last);
      if (p >= 0) begin
        cmd_q.push_back(slot[p]);
        m_busy = 1'b1; m_owner = p; m_last = p; m_dir_wr = slot[p].wr; m_busy_cnt = 0;
        m_wait = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        force_wait = -1;
        m_after_rst = 1'b0;
        clr_mask[p] = 1'b1;
      end
    end
  endtask

  task automatic drive_next();
    req_valid = req_valid & ~clr_mask;
    clr_mask = '0;
    if (m_busy) bus_ack = (m_wait == 0);
    else        bus_ack = ($urandom_range(0, 3) == 0);
    bus_rdata = (bus_ack && m_busy && force_rd_en) ? force_rd : DW'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    drive_next();
  endtask

  // Monitor: compare DUT outputs against the model away from the active edge.
  logic [N-1:0] mon_exp_ready;
  logic         prev_cmd = 1'b0;
  cmd_t         mon_c;
  rsp_t         mon_r;
  always @(negedge clk) begin
    if (m_started) begin
      mon_exp_ready = (sys_reset || m_busy) ? '0 : onehot(pick(req_valid, m_last));
      chk("req_ready", 64'(req_ready), 64'(mon_exp_ready));
      chk("bus_read", 64'(bus_rd), 64'(m_busy && !m_dir_wr));
      chk("bus_write", 64'(bus_wr), 64'(m_busy && m_dir_wr));
      if ((bus_rd || bus_wr) && !prev_cmd) begin
        chk("cmd_pending", 64'(cmd_q.size() != 0), 64'd1);
        if (cmd_q.size() != 0) begin
          mon_c = cmd_q.pop_front();
          chk("bus_address", 64'(bus_addr), 64'(mon_c.addr));
          chk("bus_byte_enable", 64'(bus_be), 64'(mon_c.be));
          if (mon_c.wr) chk("bus_write_data", 64'(bus_wdata), 64'(mon_c.data));
        end
      end
      prev_cmd = bus_rd || bus_wr;
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_due ? onehot(m_rsp_owner) : {N{1'b0}}));
      if (rsp_valid != '0) begin
        chk("rsp_pending", 64'(rsp_q.size() != 0), 64'd1);
        if (rsp_q.size() != 0) begin
          mon_r = rsp_q.pop_front();
          chk("rsp_read_data", 64'(rsp_read_data), 64'(mon_r.data));
          chk("rsp_error", 64'(rsp_error), 64'(mon_r.err));
        end
      end
      if (m_after_rst) begin
        chk("rst_address", 64'(bus_addr), 64'd0);
        chk("rst_byte_enable", 64'(bus_be), 64'd0);
        chk("rst_write_data", 64'(bus_wdata), 64'd0);
        chk("rst_rsp_read_data", 64'(rsp_read_data), 64'd0);
        chk("rst_rsp_error", 64'(rsp_error), 64'd0);
      end
    end
  end

  initial begin
    // Power-on reset.
    sys_reset = 1'b1;
    repeat (3) step();
    sys_reset = 1'b0;

    // Zero-wait-state write from requester 0.
    force_wait = 0;
    load(0, 1'b1, 30'h100, 4'hF, 32'hDEADBEEF);
    repeat (6) step();

    // Read with five wait states.
    force_wait = 5; force_rd_en = 1'b1; force_rd = 32'h12345678;
    load(1, 1'b0, 30'h200, 4'hF, 32'h0);
    repeat (10) step();
    force_rd_en = 1'b0;

    // Fairness: everyone continuously valid, single-cycle acks.
    repeat (14) begin
      force_wait = 0;
      for (int n = 0; n < N; n++) load_rand(n);
      step();
    end
    force_wait = -1;
    repeat (20) step();

    // Idle with stray acknowledge pulses.
    repeat (8) step();

    // Reset in the middle of a long read.
    force_wait = 30;
    load(2, 1'b0, 30'h3000, 4'hF, 32'h0);
    repeat (4) step();
    sys_reset = 1'b1;
    for (int n = 0; n < N; n++) load_rand(n);
    repeat (2) step();
    sys_reset = 1'b0;
    repeat (20) step();

`ifdef GPU_ARB_ACK_TIMEOUT_EN
    // Never acknowledge: watchdog must complete the transaction with an error.
    repeat (20) step();
    force_wait = 1000;
    load(0, 1'b0, 30'h44, 4'h3, 32'h0);
    repeat (15) step();
`endif

    // Randomized traffic.
    repeat (3000) begin
      for (int n = 0; n < N; n++) begin
        if ($urandom_range(0, 2) == 0) load_rand(n);
      end
      step();
    end
    repeat (40) step();

    chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpu_mem_arbiter.md
# gpu_mem_arbiter

Round-robin arbiter that shares the single GPU master port (`gpu_main_external_interface_*`) between several pipeline clients: raster pixel writes, framebuffer clear, and vertex fetch. Each client issues single-word read or write requests through a valid/ready handshake and gets back a one-cycle response pulse. The block owns the bus handshake: it holds `read`/`write` until `acknowledge` arrives, then releases the bus. It sits between the pipeline stages and the memory-mapped interconnect.

## Interface
- `NUM_REQ`, 3: number of requesters; requester 0 has first priority after reset.
- `ADDR_W`, 30: bus address width.
- `DATA_W`, 32: bus data width.
- `TIMEOUT_CYCLES`, 255: acknowledge watchdog limit; used only when `GPU_ARB_ACK_TIMEOUT_EN` is defined.
- `pll_clock` in 1: the single clock; all logic is on the rising edge.
- `sys_reset` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: one request-pending bit per requester.
- `req_ready` out NUM_REQ: one-hot grant; the request is accepted on a cycle where valid and ready are both high.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_address` in NUM_REQ*ADDR_W: packed; requester n uses slice [n*ADDR_W +: ADDR_W].
- `req_byte_enable` in NUM_REQ*4: packed byte enables.
- `req_write_data` in NUM_REQ*DATA_W: packed write data.
- `rsp_valid` out NUM_REQ: one-cycle completion pulse to the owning requester.
- `rsp_read_data` out DATA_W: shared read data; valid only while some `rsp_valid` bit is high.
- `rsp_error` out 1: qualifies `rsp_valid`; high means the transaction timed out.
- `gpu_main_external_interface_address` out 30, `_byte_enable` out 4, `_read` out 1, `_write` out 1, `_write_data` out 32: master-side bus outputs.
- `gpu_main_external_interface_acknowledge` in 1, `_read_data` in 32: master-side bus inputs.

## Operation
- FSM has two states:
  - IDLE: `req_ready` is combinational. It is one-hot on the first valid requester, searching upward from `last_grant+1` and wrapping modulo NUM_REQ. It is all-zero when no requester is valid.
  - On acceptance: latch address, byte enable, data and direction; store the grant index in `owner` and `last_grant`; go to BUSY.
  - BUSY: `req_ready` is 0. Drive the latched command, with `read` or `write` high according to direction.
  - On `acknowledge`=1: capture `read_data` (for writes, capture 0 instead), deassert `read`/`write` at the next edge, pulse `rsp_valid[owner]` for one cycle, return to IDLE.
- A requester must hold its request stable while valid and not yet ready. Dropping `req_valid` before it is granted is permitted.
- `acknowledge` sampled in IDLE is ignored.
- Reset values:
  - All outputs are 0, including address, byte_enable, read, write, write_data, req_ready, rsp_valid, rsp_read_data and rsp_error.
  - State = IDLE, `last_grant` = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction: the bus command drops at that edge, the in-flight transaction is abandoned, and no `rsp_valid` is issued.

## Timing
- Cycle T: accept in IDLE.
- Cycle T+1: `read`/`write` high. The earliest `acknowledge` is sampled in T+1, which is a zero-wait-state slave.
- Ack sampled in cycle A:
  - A+1: command low, `rsp_valid` high, FSM in IDLE, and the next grant may be given in this same cycle.
  - Peak throughput is one transaction per 2 cycles.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 transactions.

## Configuration
- `GPU_ARB_ACK_TIMEOUT_EN` defined:
  - An 8+-bit counter runs in BUSY.
  - When it reaches TIMEOUT_CYCLES without an ack, the command is deasserted, `rsp_valid[owner]` pulses with `rsp_error`=1 and `rsp_read_data`=0, and the FSM returns to IDLE.
  - An ack in the same cycle the limit is hit wins; the response is normal.
- `GPU_ARB_ACK_TIMEOUT_EN` undefined: BUSY waits indefinitely, and `rsp_error` is tied to 0.

## Structure
- The shared package `gpu_pkg` holds:
  - the arbiter state enum (IDLE, BUSY);
  - the default widths;
  - the framebuffer base constant 30'h32000000, so clients compute addresses consistently.
- One sub-module, `rr_priority_pick`: a combinational NUM_REQ-wide round-robin picker. Inputs are the valid vector and `last_grant`; outputs are a one-hot grant and its index.

## Test plan
- Single write, zero-wait: requester 0 writes addr 0x100, data 0xDEADBEEF, BE 0xF, ack in T+1. Expect `write` high for exactly 1 cycle, bus fields match, `rsp_valid[0]` at T+2.
- Read with 5 wait states: read_data 0x12345678 with ack on the 6th BUSY cycle. Expect `read` high for 6 cycles and `rsp_read_data`=0x12345678 with `rsp_valid` for one cycle.
- Fairness: all 3 requesters valid continuously with 1-cycle ack. Expect grant order 0,1,2,0,1,2, no requester starved, one grant every 2 cycles.
- Ack ignored in IDLE: pulse `acknowledge` with no request pending. Expect no `rsp_valid` and no state change.
- Reset mid-BUSY: assert `sys_reset` during a pending read. Expect the next edge to give `read`=0 and all outputs 0, with no `rsp_valid`; the first grant after release goes to requester 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): never ack. Expect the command to drop after 8 BUSY cycles, with `rsp_valid` and `rsp_error`=1 and data 0.
